alu_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_core.sv | 71 +++++++
 rtl/alu_seq.sv | 172 +++++++++++++++++
 tb/tb_alu_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, flag bit positions and FSM state for the sequenced ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_OR    = 4'd2,
        OP_AND   = 4'd3,
        OP_NOT   = 4'd4,
        OP_CMP   = 4'd5,
        OP_SHR1  = 4'd6,
        OP_SHL1  = 4'd7,
        OP_SHRN  = 4'd8,
        OP_SHLN  = 4'd9,
        OP_MUL   = 4'd10,
        OP_ASR1  = 4'd11,
        OP_ADC   = 4'd12,
        OP_SBB   = 4'd13,
        OP_RSV14 = 4'd14,
        OP_RSV15 = 4'd15
    } op_e;

    localparam int C_IDX = 3;
    localparam int N_IDX = 2;
    localparam int O_IDX = 1;
    localparam int Z_IDX = 0;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

    // Which multi-cycle operation the working registers currently hold
    typedef enum logic [1:0] {
        K_SHR = 2'd0,
        K_SHL = 2'd1,
        K_MUL = 2'd2
    } kind_e;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational add/sub/logic/single-bit shift with {C,N,O,Z} flag generation.
// Shared by the single-cycle path, the per-bit shift step and the multiply accumulate step.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] res_o,
    output logic [3:0]       flags_o
);
    localparam int M = WIDTH - 1;

    logic             cin_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] nz_src;
    logic             c;
    logic             o;

    // Result select and flag derivation; the carry-in only participates in ADC/SBB,
    // and a negative A-B-cin shows up as bit WIDTH of the extended difference (borrow).
    always_comb begin
        cin_eff = (op_i == OP_ADC || op_i == OP_SBB) ? cin_i : 1'b0;
        sum     = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_eff};
        diff    = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, cin_eff};
        res_o   = a_i;
        c       = 1'b0;
        o       = 1'b0;
        case (op_i)
            OP_ADD, OP_ADC: begin
                res_o = sum[M:0];
                c     = sum[WIDTH];
                o     = (a_i[M] == b_i[M]) && (sum[M] != a_i[M]);
            end
            OP_SUB, OP_SBB: begin
                res_o = diff[M:0];
                c     = diff[WIDTH];
                o     = (a_i[M] != b_i[M]) && (diff[M] != a_i[M]);
            end
            OP_CMP: begin
                res_o = a_i;
                c     = diff[WIDTH];
                o     = (a_i[M] != b_i[M]) && (diff[M] != a_i[M]);
            end
            OP_OR:   res_o = a_i | b_i;
            OP_AND:  res_o = a_i & b_i;
            OP_NOT:  res_o = ~a_i;
            OP_SHR1: begin
                res_o = {1'b0, a_i[M:1]};
                c     = a_i[0];
            end
            OP_SHL1: begin
                res_o = {a_i[M-1:0], 1'b0};
                c     = a_i[M];
            end
            OP_ASR1: begin
                res_o = {a_i[M], a_i[M:1]};
                c     = a_i[0];
            end
            default: ;
        endcase
        // CMP reports N/Z of the difference while passing A through
        nz_src  = (op_i == OP_CMP) ? diff[M:0] : res_o;
        flags_o = {c, nz_src[M], o, (nz_src == '0)};
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result/flags, multi-cycle N-bit shifts and
// shift-add multiply, driving the shared result bus through a tristate.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic             in_enable_out,
    output wire  [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [3:0]       flags
);
    localparam int CW = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    kind_e              kind_q, kind_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [3:0]         flags_q, flags_d;
    logic               out_valid_q, out_valid_d;

    op_e                core_op;
    logic [WIDTH-1:0]   core_a;
    logic [WIDTH-1:0]   core_b;
    logic               core_cin;
    logic [WIDTH-1:0]   core_res;
    logic [3:0]         core_flags;

    logic [SHW-1:0]     amt;
    logic               is_shn;
    logic [2*WIDTH-1:0] mul_step;
    logic               mul_hi;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op_i   (core_op),
        .a_i    (core_a),
        .b_i    (core_b),
        .cin_i  (core_cin),
        .res_o  (core_res),
        .flags_o(core_flags)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign flags     = flags_q;
    assign out       = in_enable_out ? out_q : {WIDTH{1'bz}};
    assign amt       = in_B[SHW-1:0];
    assign is_shn    = (op == OP_SHRN) || (op == OP_SHLN);

    // Core operand mux: request operands when idle, working registers during EXEC
    always_comb begin
        core_op  = op_e'(op);
        core_a   = in_A;
        core_b   = in_B;
        core_cin = flags_q[C_IDX];
        if (state_q == EXEC) begin
            core_cin = 1'b0;
            core_b   = '0;
            case (kind_q)
                K_MUL: begin
                    core_op = OP_ADD;
                    core_a  = prod_q[2*WIDTH-1:WIDTH];
                    core_b  = prod_q[0] ? mcand_q : '0;
                end
                K_SHL: begin
                    core_op = OP_SHL1;
                    core_a  = prod_q[WIDTH-1:0];
                end
                default: begin
                    core_op = OP_SHR1;
                    core_a  = prod_q[WIDTH-1:0];
                end
            endcase
        end
    end

    // Next-state logic: accept in IDLE, one shift/accumulate step per EXEC cycle
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        cnt_d       = cnt_q;
        prod_d      = prod_q;
        mcand_d     = mcand_q;
        out_d       = out_q;
        flags_d     = flags_q;
        out_valid_d = 1'b0;
        // Product register {hi, lo} shifts right each step with the adder carry on top
        mul_step    = {core_flags[C_IDX], core_res, prod_q[WIDTH-1:1]};
        mul_hi      = |mul_step[2*WIDTH-1:WIDTH];
        if (state_q == IDLE) begin
            if (in_valid) begin
                if (is_shn && (amt != '0)) begin
                    state_d = EXEC;
                    kind_d  = (op == OP_SHLN) ? K_SHL : K_SHR;
                    prod_d  = {{WIDTH{1'b0}}, in_A};
                    cnt_d   = CW'(amt);
                end else if (op == OP_MUL) begin
                    state_d = EXEC;
                    kind_d  = K_MUL;
                    prod_d  = {{WIDTH{1'b0}}, in_B};
                    mcand_d = in_A;
                    cnt_d   = CW'(WIDTH);
                end else if (is_shn) begin
                    // Zero-length shift: nothing shifted out, so C stays clear
                    out_d       = in_A;
                    flags_d     = {1'b0, in_A[WIDTH-1], 1'b0, (in_A == '0)};
                    out_valid_d = 1'b1;
                end else if (op == OP_RSV14 || op == OP_RSV15) begin
                    out_d       = in_A;
                    out_valid_d = 1'b1;
                end else begin
                    out_d       = core_res;
                    flags_d     = core_flags;
                    out_valid_d = 1'b1;
                end
            end
        end else begin
            cnt_d = cnt_q - CW'(1);
            if (kind_q == K_MUL) begin
                prod_d = mul_step;
                if (cnt_q == CW'(1)) begin
                    state_d     = IDLE;
                    out_d       = mul_step[WIDTH-1:0];
                    flags_d     = {mul_hi, mul_step[WIDTH-1], mul_hi, (mul_step[WIDTH-1:0] == '0)};
                    out_valid_d = 1'b1;
                end
            end else begin
                prod_d = {{WIDTH{1'b0}}, core_res};
                if (cnt_q == CW'(1)) begin
                    state_d     = IDLE;
                    out_d       = core_res;
                    flags_d     = core_flags;
                    out_valid_d = 1'b1;
                end
            end
        end
    end

    // State, working and result registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            kind_q      <= K_SHR;
            cnt_q       <= '0;
            prod_q      <= '0;
            mcand_q     <= '0;
            out_q       <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            cnt_q       <= cnt_d;
            prod_q      <= prod_d;
            mcand_q     <= mcand_d;
            out_q       <= out_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed scenarios plus randomized ops against an arithmetic reference model.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_enable_out = 1'b1;
    logic         in_ready;
    logic         out_valid;
    logic [3:0]   op = 4'd0;
    logic [3:0]   flags;
    logic [W-1:0] in_A = '0;
    logic [W-1:0] in_B = '0;
    wire  [W-1:0] out_w;

    int           n_tests = 0;
    int           n_fail = 0;
    logic [3:0]   mdl_flags = 4'd0;
    logic [7:0]   mdl_out = 8'd0;

    always #5 clk = ~clk;

    // Weak pull so a released bus reads as all ones
    for (genvar i = 0; i < W; i++) begin : g_pu
        pullup (out_w[i]);
    end

    alu_seq #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op           (op),
        .in_A         (in_A),
        .in_B         (in_B),
        .in_enable_out(in_enable_out),
        .out          (out_w),
        .out_valid    (out_valid),
        .flags        (flags)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: result, flags and number of busy cycles from plain integer arithmetic
    function automatic void model(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output logic [3:0] f, output int busy);
        int  ua = int'(a);
        int  ub = int'(b);
        int  sa = int'($signed(a));
        int  sb = int'($signed(b));
        int  ci = int'(mdl_flags[3]);
        int  n  = ub % 8;
        int  full = 0;
        int  s = 0;
        int  nz = 0;
        logic c = 1'b0;
        logic ov = 1'b0;
        busy = 0;
        r = a;
        case (o)
            4'd0, 4'd12: begin
                if (o == 4'd0) ci = 0;
                full = ua + ub + ci;  s = sa + sb + ci;
                r = 8'(full & 255);   c = (full > 255);  ov = (s > 127) || (s < -128);
            end
            4'd1, 4'd13, 4'd5: begin
                if (o != 4'd13) ci = 0;
                full = ua - ub - ci;  s = sa - sb - ci;
                r = 8'(full & 255);   c = (full < 0);    ov = (s > 127) || (s < -128);
            end
            4'd2: r = a | b;
            4'd3: r = a & b;
            4'd4: r = ~a;
            4'd6: begin r = 8'(ua / 2); c = a[0]; end
            4'd7: begin r = 8'((ua * 2) & 255); c = a[7]; end
            4'd11: begin r = 8'((sa >>> 1) & 255); c = a[0]; end
            4'd8: begin
                r = 8'(ua >> n);  c = (n > 0) ? 1'((ua >> (n - 1)) & 1) : 1'b0;  busy = n;
            end
            4'd9: begin
                r = 8'((ua << n) & 255);  c = (n > 0) ? 1'((ua >> (8 - n)) & 1) : 1'b0;  busy = n;
            end
            4'd10: begin
                full = ua * ub;  r = 8'(full & 255);  c = ((full >> 8) != 0);  ov = c;  busy = 8;
            end
            default: ;
        endcase
        nz = (o == 4'd5) ? (full & 255) : int'(r);
        f = {c, (nz >= 128), ov, (nz == 0)};
        if (o == 4'd5) r = a;
        if (o >= 4'd14) f = mdl_flags;
    endfunction

    // Issue one request at a negedge with in_ready high; end at the negedge showing its result
    task automatic run_op(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b, input bit noise);
        logic [7:0] er;
        logic [3:0] ef;
        int         busy;
        model(o, a, b, er, ef, busy);
        check("pre_ready", 32'(in_ready), 32'd1);
        op = o; in_A = a; in_B = b; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < busy; k++) begin
            check("busy_ready", 32'(in_ready), 32'd0);
            check("busy_valid", 32'(out_valid), 32'd0);
            check("busy_flags", 32'(flags), 32'(mdl_flags));
            check("busy_out", 32'(out_w), 32'(mdl_out));
            if (noise) begin
                in_valid = 1'b1; op = 4'($urandom); in_A = 8'($urandom); in_B = 8'($urandom);
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
        mdl_out = er;
        mdl_flags = ef;
        check("res_out", 32'(out_w), 32'(er));
        check("res_flags", 32'(flags), 32'(ef));
        check("res_valid", 32'(out_valid), 32'd1);
        check("res_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_out", 32'(out_w), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(4'd0, 8'h40, 8'h41, 1'b0);
        check("add_out", 32'(out_w), 32'h81);
        check("add_flags", 32'(flags), 32'b0110);
        @(negedge clk);
        check("add_valid_drop", 32'(out_valid), 32'd0);

        run_op(4'd1, 8'h01, 8'h80, 1'b0);
        check("sub1_flags", 32'(flags), 32'b1110);
        run_op(4'd1, 8'h80, 8'h01, 1'b0);
        check("sub2_out", 32'(out_w), 32'h7F);
        check("sub2_flags", 32'(flags), 32'b0010);
        run_op(4'd9, 8'h53, 8'h02, 1'b0);
        check("shln_out", 32'(out_w), 32'h4C);
        check("shln_flags", 32'(flags), 32'b1000);
        run_op(4'd8, 8'h53, 8'h00, 1'b0);
        check("shrn0_out", 32'(out_w), 32'h53);
        run_op(4'd10, 8'h0F, 8'h11, 1'b1);
        check("mul1_out", 32'(out_w), 32'hFF);
        check("mul1_flags", 32'(flags), 32'b0100);
        run_op(4'd10, 8'h10, 8'h10, 1'b0);
        check("mul2_flags", 32'(flags), 32'b1011);
        run_op(4'd0, 8'hFF, 8'h01, 1'b0);
        check("addc_flags", 32'(flags), 32'b1001);
        run_op(4'd12, 8'h01, 8'h01, 1'b0);
        check("adc_out", 32'(out_w), 32'h03);
        check("adc_flags", 32'(flags), 32'b0000);

        in_enable_out = 1'b0;
        #1;
        check("bus_released", 32'(out_w), 32'hFF);
        in_enable_out = 1'b1;
        #1;
        check("bus_driven", 32'(out_w), 32'h03);

        // Reset in the middle of a multiply
        op = 4'd10; in_A = 8'hFF; in_B = 8'hFF; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(in_ready), 32'd1);
        check("abort_out", 32'(out_w), 32'd0);
        check("abort_flags", 32'(flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mdl_flags = 4'd0;
        mdl_out = 8'd0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("abort_no_valid", 32'(out_valid), 32'd0);
        end
        check("abort_out_hold", 32'(out_w), 32'd0);

        for (int t = 0; t < 300; t++) begin
            run_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                check("idle_valid", 32'(out_valid), 32'd0);
                check("idle_out", 32'(out_w), 32'(mdl_out));
                check("idle_flags", 32'(flags), 32'(mdl_flags));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
